// File: rtl/lsu_mem.sv
// Load/store unit: sub-word loads and stores over a word-wide, big-endian data memory port.
// Sub-word stores are done as read-modify-write; misaligned or out-of-range accesses fault.
module lsu_mem #(
    parameter int unsigned MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] data_addr,
    output logic        data_wr,
    output logic [31:0] data_out,
    input  logic [31:0] data_in
);

    localparam logic [31:0] MemLimit = 32'(MEM_BYTES);

    typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_e;

    state_e      state;
    logic        we_q;
    logic        sext_q;
    logic [1:0]  size_q;
    logic [1:0]  off_q;
    logic [15:0] wdata_q;

    logic        fault;
    logic [31:0] base;
    logic [4:0]  lane_sh;
    logic [31:0] shifted;
    logic [7:0]  byte_val;
    logic [15:0] half_val;
    logic [31:0] load_val;
    logic [31:0] lane_mask;
    logic [31:0] merged;

    always_comb begin
        fault = (size == 2'b11) ||
                (size == 2'b01 && addr[0]) ||
                (size == 2'b10 && addr[1:0] != 2'b00) ||
                (addr >= MemLimit);
        base  = {addr[31:2], 2'b00};
    end

    // Byte at offset k sits in bits [31-8k -: 8], so shift right by 8*(3-k).
    always_comb begin
        lane_sh  = {2'd3 - off_q, 3'b000};
        shifted  = data_in >> lane_sh;
        byte_val = shifted[7:0];
        half_val = off_q[1] ? data_in[15:0] : data_in[31:16];

        case (size_q)
            2'b00:   load_val = {{24{sext_q & byte_val[7]}}, byte_val};
            2'b01:   load_val = {{16{sext_q & half_val[15]}}, half_val};
            default: load_val = data_in;
        endcase

        if (size_q == 2'b00) begin
            lane_mask = 32'h0000_00FF << lane_sh;
            merged    = (data_in & ~lane_mask) | ({4{wdata_q[7:0]}} & lane_mask);
        end else begin
            lane_mask = off_q[1] ? 32'h0000_FFFF : 32'hFFFF_0000;
            merged    = (data_in & ~lane_mask) | ({2{wdata_q}} & lane_mask);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            we_q      <= 1'b0;
            sext_q    <= 1'b0;
            size_q    <= 2'b00;
            off_q     <= 2'b00;
            wdata_q   <= 16'h0000;
            rdata     <= 32'h0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            data_addr <= 32'h0;
            data_wr   <= 1'b0;
            data_out  <= 32'h0;
        end else begin
            case (state)
                StIdle: begin
                    if (req) begin
                        we_q    <= we;
                        size_q  <= size;
                        sext_q  <= sign_ext;
                        off_q   <= addr[1:0];
                        wdata_q <= wdata[15:0];
                        busy    <= 1'b1;
                        if (fault) begin
                            state <= StDone;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else if (we && size == 2'b10) begin
                            // Full-word store needs no read: write straight away.
                            state     <= StWr;
                            data_addr <= base;
                            data_wr   <= 1'b1;
                            data_out  <= wdata;
                        end else begin
                            state     <= StRd;
                            data_addr <= base;
                        end
                    end
                end
                StRd: begin
                    if (!we_q) begin
                        state <= StDone;
                        done  <= 1'b1;
                        rdata <= load_val;
                    end else begin
                        state    <= StWr;
                        data_wr  <= 1'b1;
                        data_out <= merged;
                    end
                end
                StWr: begin
                    state   <= StDone;
                    data_wr <= 1'b0;
                    done    <= 1'b1;
                end
                StDone: begin
                    state <= StIdle;
                    done  <= 1'b0;
                    err   <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem.sv
// Self-checking bench for lsu_mem: byte-array reference model, directed and random accesses,
// fault, back-to-back, mid-flight reset and req-while-busy scenarios.
module tb_lsu_mem;

    logic        clk = 1'b0;
    logic        rst_n, req, we, sign_ext;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic [31:0] rdata, data_addr, data_out, data_in;
    logic        busy, done, err, data_wr;

    int errors = 0;
    int checks = 0;
    int wr_cycles = 0;

    logic [31:0] mem [0:255];
    logic [7:0]  rb  [0:1023];
    logic [31:0] last_rdata = 32'h0;

    always #5 clk = ~clk;

    lsu_mem #(.MEM_BYTES(1024)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
        .addr(addr), .wdata(wdata), .rdata(rdata), .busy(busy), .done(done), .err(err),
        .data_addr(data_addr), .data_wr(data_wr), .data_out(data_out), .data_in(data_in)
    );

    assign data_in = mem[data_addr[9:2]];

    always @(posedge clk) begin
        if (data_wr) begin
            mem[data_addr[9:2]] <= data_out;
            wr_cycles <= wr_cycles + 1;
        end
    end

    task automatic preset(input int a, input logic [31:0] w);
        mem[a >> 2] = w;
        rb[a] = w[31:24]; rb[a+1] = w[23:16]; rb[a+2] = w[15:8]; rb[a+3] = w[7:0];
    endtask

    function automatic logic [31:0] model_word(input int a);
        return {rb[a], rb[a+1], rb[a+2], rb[a+3]};
    endfunction

    function automatic logic model_fault(input logic [1:0] sz, input logic [31:0] a);
        return sz == 2'd3 || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) ||
               a >= 32'd1024;
    endfunction

    function automatic logic [31:0] model_load(input int a, input logic [1:0] sz, input logic sx);
        logic [15:0] h;
        case (sz)
            2'd0: return sx ? 32'($signed(rb[a])) : {24'h0, rb[a]};
            2'd1: begin
                h = {rb[a], rb[a+1]};
                return sx ? 32'($signed(h)) : {16'h0, h};
            end
            default: return model_word(a);
        endcase
    endfunction

    task automatic model_store(input int a, input logic [1:0] sz, input logic [31:0] wd);
        case (sz)
            2'd0: rb[a] = wd[7:0];
            2'd1: begin rb[a] = wd[15:8]; rb[a+1] = wd[7:0]; end
            default: begin
                rb[a] = wd[31:24]; rb[a+1] = wd[23:16]; rb[a+2] = wd[15:8]; rb[a+3] = wd[7:0];
            end
        endcase
    endtask

    // Issues one access and records what the DUT did; lat = -1 if done never came.
    task automatic access(input logic iwe, input logic [1:0] isz, input logic isx,
                          input logic [31:0] ia, input logic [31:0] iwd,
                          output int lat, output int nwr, output int wk,
                          output logic [31:0] wa, output logic [31:0] wd,
                          output logic [31:0] rd, output logic e);
        lat = -1; nwr = 0; wk = -1; wa = 32'h0; wd = 32'h0; rd = 32'h0; e = 1'b0;
        @(negedge clk);
        req = 1'b1; we = iwe; size = isz; sign_ext = isx; addr = ia; wdata = iwd;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            req = 1'b0;
            if (data_wr) begin
                nwr++;
                if (wk < 0) wk = k;
                wa = data_addr;
                wd = data_out;
            end
            if (done) begin
                lat = k;
                rd  = rdata;
                e   = err;
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = 1'b0; we = 1'b0; size = 2'd0; sign_ext = 1'b0;
        addr = 32'h0; wdata = 32'h0;
        repeat (2) @(negedge clk);
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        checks++; if (data_addr !== 32'h0) begin errors++; $display("FAIL reset_data_addr: got %h want 0", data_addr); end
        checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL reset_data_out: got %h want 0", data_out); end
        checks++; if ({busy, done, err, data_wr} !== 4'b0) begin
            errors++; $display("FAIL reset_flags: got %b want 0000", {busy, done, err, data_wr});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_loads();
        logic [31:0] ta [5] = '{32'h10, 32'h20, 32'h22, 32'h20, 32'h22};
        logic [1:0]  ts [5] = '{2'd2, 2'd0, 2'd0, 2'd1, 2'd1};
        logic        tx [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [31:0] te [5] = '{32'h11223344, 32'hFFFFFF80, 32'h0000007F, 32'hFFFF80FF,
                                32'h00007F01};
        int lat, nwr, wk; logic [31:0] wa, wd, rd; logic e;
        preset(32'h10, 32'h11223344);
        preset(32'h20, 32'h80FF7F01);
        for (int i = 0; i < 5; i++) begin
            access(1'b0, ts[i], tx[i], ta[i], 32'h0, lat, nwr, wk, wa, wd, rd, e);
            checks++; if (rd !== te[i]) begin errors++; $display("FAIL load%0d_rdata: got %h want %h", i, rd, te[i]); end
            checks++; if (lat != 2) begin errors++; $display("FAIL load%0d_latency: got %0d want 2", i, lat); end
            checks++; if (e !== 1'b0 || nwr != 0) begin
                errors++; $display("FAIL load%0d_err_wr: got err=%b wr=%0d want 0/0", i, e, nwr);
            end
            last_rdata = te[i];
        end
    endtask

    task automatic test_stores();
        int lat, nwr, wk; logic [31:0] wa, wd, rd; logic e;
        access(1'b1, 2'd0, 1'b0, 32'h11, 32'h000000AB, lat, nwr, wk, wa, wd, rd, e);
        model_store(32'h11, 2'd0, 32'h000000AB);
        checks++; if (lat != 3) begin errors++; $display("FAIL sb_latency: got %0d want 3", lat); end
        checks++; if (nwr != 1 || wa !== 32'h10 || wd !== 32'h11AB3344) begin
            errors++; $display("FAIL sb_write: got n=%0d a=%h d=%h want 1/10/11ab3344", nwr, wa, wd);
        end
        access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, lat, nwr, wk, wa, wd, rd, e);
        last_rdata = rd;
        checks++; if (rd !== 32'h11AB3344) begin errors++; $display("FAIL sb_readback: got %h want 11ab3344", rd); end

        access(1'b1, 2'd2, 1'b0, 32'h30, 32'hDEADBEEF, lat, nwr, wk, wa, wd, rd, e);
        model_store(32'h30, 2'd2, 32'hDEADBEEF);
        checks++; if (wk != 1 || lat != 2 || nwr != 1) begin
            errors++; $display("FAIL sw_timing: got wr@%0d done@%0d n=%0d want 1/2/1", wk, lat, nwr);
        end
        access(1'b1, 2'd1, 1'b0, 32'h32, 32'h00001234, lat, nwr, wk, wa, wd, rd, e);
        model_store(32'h32, 2'd1, 32'h00001234);
        checks++; if (wk != 2 || lat != 3 || wd !== 32'hDEAD1234) begin
            errors++; $display("FAIL sh_write: got wr@%0d done@%0d d=%h want 2/3/dead1234", wk, lat, wd);
        end
        access(1'b0, 2'd2, 1'b0, 32'h30, 32'h0, lat, nwr, wk, wa, wd, rd, e);
        last_rdata = rd;
        checks++; if (rd !== 32'hDEAD1234) begin errors++; $display("FAIL sh_readback: got %h want dead1234", rd); end
    endtask

    task automatic test_faults();
        logic        fw [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [1:0]  fs [4] = '{2'd2, 2'd1, 2'd3, 2'd0};
        logic [31:0] fa [4] = '{32'h12, 32'h21, 32'h10, 32'h400};
        int lat, nwr, wk; logic [31:0] wa, wd, rd; logic e;
        for (int i = 0; i < 4; i++) begin
            access(fw[i], fs[i], 1'b1, fa[i], 32'hFFFFFFFF, lat, nwr, wk, wa, wd, rd, e);
            checks++; if (lat != 1 || e !== 1'b1) begin
                errors++; $display("FAIL fault%0d_done_err: got done@%0d err=%b want 1/1", i, lat, e);
            end
            checks++; if (nwr != 0) begin errors++; $display("FAIL fault%0d_no_write: got %0d want 0", i, nwr); end
            checks++; if (rd !== last_rdata) begin
                errors++; $display("FAIL fault%0d_rdata_held: got %h want %h", i, rd, last_rdata);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0]  dmask = '0;
        logic [9:0]  bmask = '0;
        logic [31:0] exp = model_load(32'h10, 2'd2, 1'b0);
        @(negedge clk);
        req = 1'b1; we = 1'b0; size = 2'd2; sign_ext = 1'b0; addr = 32'h10;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            dmask[k] = done;
            bmask[k] = busy;
            if (done) begin
                checks++; if (rdata !== exp) begin errors++; $display("FAIL b2b_rdata@%0d: got %h want %h", k, rdata, exp); end
            end
            if (k == 9) req = 1'b0;
        end
        last_rdata = exp;
        checks++; if (dmask !== 10'b01_0010_0100) begin
            errors++; $display("FAIL b2b_done_pattern: got %b want 0100100100", dmask);
        end
        checks++; if (bmask !== 10'b01_1011_0110) begin
            errors++; $display("FAIL b2b_busy_pattern: got %b want 0110110110", bmask);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_midflight();
        int w0;
        int lat, nwr, wk; logic [31:0] wa, wd, rd; logic e;
        preset(32'h40, 32'hCAFEF00D);
        w0 = wr_cycles;
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = 2'd0; sign_ext = 1'b0; addr = 32'h41; wdata = 32'h55;
        @(negedge clk);
        req = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy_before: got %b want 1", busy); end
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++; if ({rdata, data_addr, data_out, busy, done, err, data_wr} !== '0) begin
                errors++; $display("FAIL rst_outputs_low%0d: got %h/%h/%h/%b%b%b%b want all 0", k,
                                   rdata, data_addr, data_out, busy, done, err, data_wr);
            end
            @(negedge clk);
        end
        rst_n = 1'b1;
        last_rdata = 32'h0;
        repeat (2) @(negedge clk);
        checks++; if (wr_cycles != w0) begin errors++; $display("FAIL rst_no_write: got %0d want %0d", wr_cycles, w0); end
        access(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, lat, nwr, wk, wa, wd, rd, e);
        last_rdata = rd;
        checks++; if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL rst_mem_intact: got %h want cafef00d", rd); end
    endtask

    task automatic test_req_busy();
        int w0;
        logic [4:0]  dmask = '0;
        logic [31:0] got = 32'h0;
        int lat, nwr, wk; logic [31:0] wa, wd, rd; logic e;
        preset(32'h50, 32'h0BADC0DE);
        w0 = wr_cycles;
        @(negedge clk);
        req = 1'b1; we = 1'b0; size = 2'd2; sign_ext = 1'b0; addr = 32'h50;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            dmask[k] = done;
            if (done) got = rdata;
            // Flip to a conflicting store request while busy, then drop req.
            req = (k == 1);
            we = 1'b1; addr = 32'h50; wdata = 32'hFFFFFFFF;
        end
        req = 1'b0;
        checks++; if (dmask !== 5'b00100) begin errors++; $display("FAIL busy_req_done_pattern: got %b want 00100", dmask); end
        checks++; if (got !== 32'h0BADC0DE) begin errors++; $display("FAIL busy_req_rdata: got %h want 0badc0de", got); end
        checks++; if (wr_cycles != w0) begin errors++; $display("FAIL busy_req_no_write: got %0d want %0d", wr_cycles, w0); end
        access(1'b0, 2'd2, 1'b0, 32'h50, 32'h0, lat, nwr, wk, wa, wd, rd, e);
        last_rdata = rd;
        checks++; if (rd !== 32'h0BADC0DE) begin errors++; $display("FAIL busy_req_mem: got %h want 0badc0de", rd); end
    endtask

    task automatic test_random();
        int lat, nwr, wk; logic [31:0] wa, wd, rd; logic e;
        logic iwe, isx, f; logic [1:0] isz; logic [31:0] ia, iwd, exp_rd;
        int exp_lat;
        for (int n = 0; n < 300; n++) begin
            iwe = 1'($urandom % 2);
            isz = 2'($urandom % 4);
            isx = 1'($urandom % 2);
            iwd = $urandom;
            if ($urandom % 8 == 0) ia = $urandom;
            else ia = 32'($urandom_range(0, 1023));
            if ($urandom % 2 == 0) begin
                if (isz == 2'd1) ia[0] = 1'b0;
                if (isz == 2'd2) ia[1:0] = 2'b00;
            end
            f = model_fault(isz, ia);
            exp_lat = f ? 1 : ((iwe && isz != 2'd2) ? 3 : 2);
            access(iwe, isz, isx, ia, iwd, lat, nwr, wk, wa, wd, rd, e);
            if (!f && !iwe) last_rdata = model_load(int'(ia), isz, isx);
            exp_rd = last_rdata;
            checks++; if (lat != exp_lat || e !== f) begin
                errors++; $display("FAIL rand%0d_timing: got done@%0d err=%b want %0d/%b", n, lat, e, exp_lat, f);
            end
            checks++; if (rd !== exp_rd) begin errors++; $display("FAIL rand%0d_rdata: got %h want %h", n, rd, exp_rd); end
            checks++; if (nwr != ((!f && iwe) ? 1 : 0)) begin
                errors++; $display("FAIL rand%0d_wr_count: got %0d want %0d", n, nwr, (!f && iwe) ? 1 : 0);
            end
            if (!f && iwe) begin
                model_store(int'(ia), isz, iwd);
                checks++; if (wa !== {ia[31:2], 2'b00} || wd !== model_word(int'({ia[31:2], 2'b00}))) begin
                    errors++; $display("FAIL rand%0d_write: got %h@%h want %h@%h", n, wd, wa,
                                       model_word(int'({ia[31:2], 2'b00})), {ia[31:2], 2'b00});
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) preset(i * 4, $urandom);
        test_reset();
        test_loads();
        test_stores();
        test_faults();
        test_back_to_back();
        test_reset_midflight();
        test_req_busy();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/lsu_mem.md
# lsu_mem

Load/store unit sitting between the CPU datapath and the data memory. Accepts one byte, halfword or word access at a time, drives the data memory's word-wide, big-endian, byte-addressed port, and performs read-modify-write for sub-word stores, since the memory writes only full 32-bit words. Returns aligned, sign- or zero-extended load data and flags misaligned or out-of-range accesses.

## Interface
- MEM_BYTES, 1024: data memory size in bytes; valid addresses are 0..MEM_BYTES-1.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  1  access request; sampled only in IDLE.
- we  in  1  1 = store, 0 = load.
- size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- sign_ext  in  1  loads only; 1 = sign-extend, 0 = zero-extend.
- addr  in  32  byte address.
- wdata  in  32  store data, LSB-aligned: byte in [7:0], half in [15:0].
- rdata  out  32  load result; valid when done=1 for a load; holds until the next load completes.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  high with done on a faulted access.
- data_addr  out  32  word-aligned address to data memory.
- data_wr  out  1  data memory write enable.
- data_out  out  32  write word to data memory.
- data_in  in  32  read word from data memory; combinational from data_addr.

## Operation
- On req=1 in IDLE, latch we, size, sign_ext, addr and wdata. Compute base = {addr[31:2], 2'b00} and off = addr[1:0]. The request is then checked:
  - Fault if size=11, or size=01 with off[0]=1, or size=10 with off!=0, or addr >= MEM_BYTES. A fault goes to DONE with err=1. No memory cycle is performed and rdata is unchanged.
  - A word store goes to WR.
  - Any other request goes to RD.
- RD (1 cycle): data_addr=base. data_in is captured into the word register at the end of the cycle.
  - A load goes to DONE.
  - A sub-word store goes to WR.
- WR (1 cycle): data_wr=1, data_addr=base, data_out=merged word. Goes to DONE.
- DONE (1 cycle): done=1, err as computed. For a load, rdata updates on entry to DONE. Goes to IDLE.
- Byte lanes are big-endian:
  - Byte at off k occupies bits [31-8k -: 8].
  - Half at off 0 occupies [31:16]; half at off 2 occupies [15:0].
- Loads: the selected field is right-justified, then extended per sign_ext. A word load ignores sign_ext.
- Sub-word store merge: the word read in RD has only the addressed lane(s) replaced by wdata[7:0] or wdata[15:0].
- data_addr holds the last base when not in RD/WR. data_out holds its last value. data_wr=0 outside WR.
- req while busy=1 is ignored. Inputs are not re-sampled until IDLE.

## Timing
- Reset values: state IDLE, rdata=0, data_addr=0, data_out=0, data_wr=0, busy=0, done=0, err=0.
- Asserting rst_n=0 in any state returns to IDLE immediately. data_wr drops asynchronously, so no partial write occurs. An in-flight access is discarded with no done.
- Latency, counted from the req-sampling edge E to the cycle in which done=1:
  - Load: E+2.
  - Word store: E+2.
  - Sub-word store: E+3.
  - Fault: E+1.
- Memory write takes effect at the edge ending WR. Exactly one data_wr cycle occurs per store; none occurs per load or fault.
- Back-to-back: req held high re-arms in the cycle after DONE (IDLE samples). Throughput is therefore one access per 3 cycles for a load and 4 cycles for a sub-word store.
- busy rises in the cycle after E and falls when returning to IDLE.

## Test plan
- Memory word 0x10 = 0x11223344; load word at addr 0x10 -> done at E+2, rdata=0x11223344, err=0, data_wr never high.
- Memory word 0x20 = 0x80FF7F01; check each load variant:
  - Signed byte at 0x20 -> 0xFFFFFF80.
  - Unsigned byte at 0x22 -> 0x0000007F.
  - Signed half at 0x20 -> 0xFFFF80FF.
  - Signed half at 0x22 -> 0x00007F01.
- Byte store wdata=0x000000AB at 0x11 over 0x11223344 -> one data_wr cycle with data_addr=0x10 and data_out=0x11AB3344; done at E+3. A follow-up word load at 0x10 -> 0x11AB3344.
- Word store 0xDEADBEEF at 0x30 -> data_wr high in cycle E+1, done at E+2. A half store 0x1234 at 0x32 -> memory word reads back 0xDEAD1234.
- Fault checks, each expecting done=err=1 at E+1, no data_wr, and rdata unchanged:
  - Word load at 0x12.
  - Half store at 0x21.
  - size=11.
  - Byte load at 0x400 (MEM_BYTES=1024).
- Robustness checks:
  - rst_n pulsed low during RD of a byte store -> data_wr never asserts, memory unchanged, busy=0 and all outputs at reset values while low.
  - req toggled during busy -> ignored; only the original access completes.
